rc4_stream_core: RTL and testbench
==================================

// Module: rc4_stream_core
// PURPOSE
//  Parametrised RC4 keystream generator, successor to the fixed 4-byte-key core.
//  Runs S-box init, KSA and PRGA on an internal 256x8 S-box, variable key length up to KEY_BYTES_MAX.
//  Streams a programmable number of keystream bytes over a valid/ready handshake.
//  Sits between the key/config register block and the XOR cipher datapath.
// PARAMETERS
//  KEY_BYTES_MAX  16   largest supported key, bytes (1..256)
//  KEY_LEN_W      5    width of key_len, must hold KEY_BYTES_MAX
//  CNT_W          16   width of ks_count and the internal byte counter
//  DROP_N         768  keystream bytes discarded when RC4_DROP_EN is defined
// PORTS
//  clk       in   1                  clock, all logic on rising edge
//  rst_n     in   1                  asynchronous active-low reset
//  start     in   1                  request new session; sampled only in IDLE
//  abort     in   1                  synchronous abort, any state -> IDLE
//  key       in   8*KEY_BYTES_MAX    key; byte n = key[8n+7:8n]
//  key_len   in   KEY_LEN_W          key length in bytes, legal 1..KEY_BYTES_MAX
//  ks_count  in   CNT_W              keystream bytes to emit; 0 = unbounded until abort
//  ks_valid  out  1                  ks_data valid
//  ks_ready  in   1                  consumer accepts byte when ks_valid & ks_ready
//  ks_data   out  8                  keystream byte
//  ks_last   out  1                  high with final byte (never when ks_count==0)
//  busy      out  1                  high in every state except IDLE
//  done      out  1                  one-cycle pulse after last byte accepted
//  err       out  1                  one-cycle pulse: start with illegal key_len
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, i=j=0; S-box contents undefined until INIT.
//  key, key_len, ks_count captured on start accept; later changes ignored.
//  FSM: IDLE -> INIT (256 cycles, S[n]=n) -> KSA (256 iters x 4 cycles) -> PRGA -> IDLE.
//  KSA iter: RD_I(addr=i) RD_J(Si latched, j+=Si+key[kidx], addr=j) WR_I(S[i]=Sj) WR_J(S[j]=Si).
//  kidx is a counter wrapping at key_len-1 (no modulo hardware); i,j wrap mod 256 naturally.
//  PRGA byte: i+=1, RD_I, RD_J, WR_I, WR_J, RD_T(addr=Si+Sj mod 256), OUT.
//  i==j: sequential writes store same value; no special-case logic.
//  OUT: ks_valid held high, ks_data stable until ks_ready; next byte starts the cycle after accept.
//  Timing: start sampled at edge 0; INIT cycles 1-256, KSA 257-1280, first ks_valid in cycle 1286.
//  Steady state: 6 cycles/byte with ks_ready held high.
//  ks_count reached: ks_last with last byte, done pulses cycle after accept, FSM IDLE.
//  key_len==0 or >KEY_BYTES_MAX: start ignored, err pulse, FSM stays IDLE.
//  start while busy ignored. abort: ks_valid low next cycle, IDLE, no done pulse.
//  Async reset mid-session: immediate return to reset values; new start re-runs INIT.
// CONFIGURATION
//  RC4_DROP_EN defined: after KSA, DROP_N PRGA bytes generated with ks_valid low (RC4-drop[n]);
//    ks_count counts only emitted bytes; busy stays high during drop.
//  RC4_DROP_EN undefined: first PRGA byte is emitted; DROP_N unused.
// STRUCTURE
//  rc4_pkg: FSM state enum, SBOX_DEPTH=256, SBOX_AW=8, per-step cycle constants.
//  Sub-module rc4_sbox_ram: 256x8 single-port RAM, sync write, 1-cycle registered read.
//  Top holds FSM, i/j/kidx/byte counters, Si/Sj latches, output register.
// TESTING
//  key="Key"(4B 65 79), len 3, count 10 -> EB 9F 77 81 B7 34 CA 72 A7 19, ks_last on 19, done.
//  key="Wiki", len 4, count 6, random ks_ready stalls -> 60 44 DB 6D 41 B7, data stable while stalled.
//  key="Secret", len 6, ready high -> 04 D4 6B 05 3C A8 7B 59; first valid cycle 1286, then every 6.
//  key_len=0 and key_len=KEY_BYTES_MAX+1 -> err pulse, busy stays 0; 16-byte key matches model.
//  abort mid-KSA and rst_n low mid-PRGA -> IDLE/reset values; restart reproduces "Key" vector.
//  RC4_DROP_EN, DROP_N=768, key="Key" -> first emitted byte equals model byte index 768.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: state encoding and S-box geometry shared by the RC4 keystream core.
package rc4_pkg;

   localparam int unsigned SBOX_DEPTH  = 256;
   localparam int unsigned SBOX_AW     = 8;
   localparam int unsigned INIT_CYCLES = SBOX_DEPTH;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_K_RDI,
      ST_K_RDJ,
      ST_K_WRI,
      ST_K_WRJ,
      ST_P_RDI,
      ST_P_RDJ,
      ST_P_WRI,
      ST_P_WRJ,
      ST_P_RDT,
      ST_P_OUT
   } rc4_state_e;

endpackage

// File: rtl/rc4_sbox_ram.sv
// rc4_sbox_ram: 256x8 single-port S-box store, synchronous write, registered read.
module rc4_sbox_ram
   import rc4_pkg::*;
(
   input  logic               clk,
   input  logic               we_i,
   input  logic [SBOX_AW-1:0] addr_i,
   input  logic [7:0]         wdata_i,
   output logic [7:0]         rdata_o
);

   logic [7:0] mem_q [SBOX_DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/rc4_stream_core.sv
// rc4_stream_core: RC4 keystream generator (INIT, KSA, PRGA) streaming bytes over valid/ready.
// Optional RC4_DROP_EN discards the first DROP_N PRGA bytes (RC4-drop[n]).
module rc4_stream_core
   import rc4_pkg::*;
#(
   parameter int unsigned KEY_BYTES_MAX = 16,
   parameter int unsigned KEY_LEN_W     = 5,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned DROP_N        = 768
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [8*KEY_BYTES_MAX-1:0] key,
   input  logic [KEY_LEN_W-1:0]       key_len,
   input  logic [CNT_W-1:0]           ks_count,
   output logic                       ks_valid,
   input  logic                       ks_ready,
   output logic [7:0]                 ks_data,
   output logic                       ks_last,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam logic [KEY_LEN_W-1:0] KLEN_MAX  = KEY_LEN_W'(KEY_BYTES_MAX);
   localparam logic [SBOX_AW-1:0]   IDX_LAST  = SBOX_AW'(SBOX_DEPTH - 1);
   localparam logic [SBOX_AW-1:0]   INIT_LAST = SBOX_AW'(INIT_CYCLES - 1);
   localparam int unsigned          DROP_W    = $clog2(DROP_N + 2);
   localparam logic [DROP_W-1:0]    DROP_LIM  = DROP_W'(DROP_N);
`ifdef RC4_DROP_EN
   localparam logic DROP_ON = 1'b1;
`else
   localparam logic DROP_ON = 1'b0;
`endif

   rc4_state_e                 state_q, state_d;
   logic [SBOX_AW-1:0]         i_q, j_q;
   logic [7:0]                 si_q, sj_q;
   logic [KEY_LEN_W-1:0]       kidx_q, klen_q;
   logic [8*KEY_BYTES_MAX-1:0] key_q;
   logic [CNT_W-1:0]           cnt_q, cnt_lim_q;
   logic [DROP_W-1:0]          drop_q;
   logic                       done_q, err_q;

   logic               ram_we;
   logic [SBOX_AW-1:0] ram_addr;
   logic [7:0]         ram_wdata, ram_rdata;
   logic [7:0]         key_byte, j_sum;
   logic               len_ok, start_ok, start_bad, accept, last, drop_pend;

   rc4_sbox_ram u_sbox (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      key_byte = '0;
      for (int unsigned b = 0; b < KEY_BYTES_MAX; b++)
         if (kidx_q == KEY_LEN_W'(b)) key_byte = key_q[8*b +: 8];
   end

   assign len_ok    = (key_len != '0) && (key_len <= KLEN_MAX);
   assign start_ok  = (state_q == ST_IDLE) && start && !abort && len_ok;
   assign start_bad = (state_q == ST_IDLE) && start && !abort && !len_ok;
   assign accept    = (state_q == ST_P_OUT) && ks_ready;
   assign last      = (cnt_lim_q != '0) && (cnt_q == cnt_lim_q - CNT_W'(1));
   assign drop_pend = DROP_ON && (drop_q != DROP_LIM);
   // The key byte only joins the j update during KSA; PRGA reuses the same adder.
   assign j_sum     = j_q + ram_rdata + ((state_q == ST_K_RDJ) ? key_byte : 8'h00);
   assign done      = done_q;
   assign err       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_INIT;
         ST_INIT:  if (i_q == INIT_LAST) state_d = ST_K_RDI;
         ST_K_RDI: state_d = ST_K_RDJ;
         ST_K_RDJ: state_d = ST_K_WRI;
         ST_K_WRI: state_d = ST_K_WRJ;
         ST_K_WRJ: state_d = (i_q == IDX_LAST) ? ST_P_RDI : ST_K_RDI;
         ST_P_RDI: state_d = ST_P_RDJ;
         ST_P_RDJ: state_d = ST_P_WRI;
         ST_P_WRI: state_d = ST_P_WRJ;
         ST_P_WRJ: state_d = ST_P_RDT;
         ST_P_RDT: state_d = drop_pend ? ST_P_RDI : ST_P_OUT;
         ST_P_OUT: if (ks_ready) state_d = last ? ST_IDLE : ST_P_RDI;
         default:  state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   // WR_I stores the just-read S[j] straight from the RAM output; WR_J stores latched S[i].
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = i_q;
      ram_wdata = ram_rdata;
      ks_valid  = 1'b0;
      ks_data   = '0;
      ks_last   = 1'b0;
      busy      = (state_q != ST_IDLE);
      case (state_q)
         ST_INIT: begin
            ram_we    = 1'b1;
            ram_wdata = i_q;
         end
         ST_K_RDJ, ST_P_RDJ: ram_addr = j_sum;
         ST_K_WRI, ST_P_WRI: ram_we = 1'b1;
         ST_K_WRJ, ST_P_WRJ: begin
            ram_we    = 1'b1;
            ram_addr  = j_q;
            ram_wdata = si_q;
         end
         ST_P_RDI: ram_addr = i_q + 8'd1;
         ST_P_RDT: ram_addr = si_q + sj_q;
         ST_P_OUT: begin
            ram_addr = si_q + sj_q;
            ks_valid = 1'b1;
            ks_data  = ram_rdata;
            ks_last  = last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q       <= '0;
         j_q       <= '0;
         si_q      <= '0;
         sj_q      <= '0;
         kidx_q    <= '0;
         klen_q    <= '0;
         key_q     <= '0;
         cnt_q     <= '0;
         cnt_lim_q <= '0;
         drop_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= accept && last && !abort;
         err_q  <= start_bad;
         case (state_q)
            ST_IDLE: if (start_ok) begin
               key_q     <= key;
               klen_q    <= key_len;
               cnt_lim_q <= ks_count;
               cnt_q     <= '0;
               drop_q    <= '0;
               i_q       <= '0;
               j_q       <= '0;
               kidx_q    <= '0;
            end
            ST_INIT: i_q <= i_q + 8'd1;
            ST_K_RDJ, ST_P_RDJ: begin
               si_q <= ram_rdata;
               j_q  <= j_sum;
            end
            ST_K_WRI, ST_P_WRI: sj_q <= ram_rdata;
            ST_K_WRJ: begin
               i_q    <= i_q + 8'd1;
               kidx_q <= (kidx_q == klen_q - KEY_LEN_W'(1)) ? '0 : kidx_q + KEY_LEN_W'(1);
               if (i_q == IDX_LAST) j_q <= '0;
            end
            ST_P_RDI: i_q <= i_q + 8'd1;
            ST_P_RDT: if (drop_pend) drop_q <= drop_q + DROP_W'(1);
            ST_P_OUT: if (accept) cnt_q <= cnt_q + CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_stream_core.sv
// tb_rc4_stream_core: directed checks of rc4_stream_core against published RC4 vectors.
// With RC4_DROP_EN defined only the drop-mode vector is exercised.
`timescale 1ns/1ps
module tb_rc4_stream_core;

   localparam int unsigned KB  = 16;
   localparam int unsigned KLW = 5;
   localparam int unsigned CW  = 16;
   localparam int unsigned DN  = 768;

   localparam logic [8*KB-1:0] KEY_KEY    = 128'h79654B;
   localparam logic [8*KB-1:0] KEY_WIKI   = 128'h696B6957;
   localparam logic [8*KB-1:0] KEY_SECRET = 128'h746572636553;
   localparam logic [8*KB-1:0] KEY_16     = 128'h100F0E0D0C0B0A090807060504030201;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic            ks_ready = 1'b0;
   logic [8*KB-1:0] key = '0;
   logic [KLW-1:0]  key_len = '0;
   logic [CW-1:0]   ks_count = '0;
   logic            ks_valid, ks_last, busy, done, err;
   logic [7:0]      ks_data;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         t0 = 0;
   logic [7:0] exp_b [0:31];
   int         vt    [0:31];
   logic [7:0] mdl   [0:1023];

   rc4_stream_core #(
      .KEY_BYTES_MAX (KB),
      .KEY_LEN_W     (KLW),
      .CNT_W         (CW),
      .DROP_N        (DN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .key      (key),
      .key_len  (key_len),
      .ks_count (ks_count),
      .ks_valid (ks_valid),
      .ks_ready (ks_ready),
      .ks_data  (ks_data),
      .ks_last  (ks_last),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic load_exp(input logic [255:0] v, input int n);
      for (int k = 0; k < n; k++) exp_b[k] = v[8*(n-1-k) +: 8];
   endtask

   task automatic begin_session(input logic [8*KB-1:0] k, input int len, input int cnt);
      key      = k;
      key_len  = KLW'(len);
      ks_count = CW'(cnt);
      start    = 1'b1;
      t0       = cyc;
      tick();
      start    = 1'b0;
   endtask

   task automatic collect(input string tag, input int n, input bit stall, input bit bounded);
      int         k = 0;
      int         budget = 0;
      bit         holding = 1'b0;
      logic [7:0] held = '0;
      while (k < n && budget < 8000) begin
         ks_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         if (holding) begin
            chk({tag, " held valid"}, 32'(ks_valid), 32'd1);
            chk({tag, " held data"}, 32'(ks_data), 32'(held));
         end else if (ks_valid) begin
            vt[k] = cyc - t0;
            chk($sformatf("%s byte %0d", tag, k), 32'(ks_data), 32'(exp_b[k]));
            chk($sformatf("%s last %0d", tag, k), 32'(ks_last),
                (bounded && k == n - 1) ? 32'd1 : 32'd0);
         end
         if (ks_valid && ks_ready) begin
            k++;
            holding = 1'b0;
         end else if (ks_valid) begin
            holding = 1'b1;
            held    = ks_data;
         end
         tick();
         budget++;
      end
      chk({tag, " bytes received"}, 32'(k), 32'(n));
      ks_ready = 1'b0;
   endtask

   task automatic chk_done(input string tag);
      chk({tag, " done pulse"}, 32'(done), 32'd1);
      chk({tag, " busy after"}, 32'(busy), 32'd0);
      tick();
      chk({tag, " done cleared"}, 32'(done), 32'd0);
   endtask

   task automatic rc4_model(input logic [8*KB-1:0] k, input int len, input int n);
      logic [7:0]      s [0:255];
      logic [7:0]      t;
      logic [8*KB-1:0] ks;
      int              i, j;
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      j = 0;
      for (int x = 0; x < 256; x++) begin
         ks = k >> (8 * (x % len));
         j  = (j + int'(s[x]) + int'(ks[7:0])) % 256;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      i = 0;
      j = 0;
      for (int x = 0; x < n; x++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         mdl[x] = s[(int'(s[i]) + int'(s[j])) % 256];
      end
   endtask

   initial begin
      tick();
      tick();
      chk("reset ks_valid", 32'(ks_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset ks_data", 32'(ks_data), 32'd0);
      chk("reset ks_last", 32'(ks_last), 32'd0);
      rst_n = 1'b1;
      tick();

`ifdef RC4_DROP_EN
      rc4_model(KEY_KEY, 3, DN + 4);
      for (int k = 0; k < 4; k++) exp_b[k] = mdl[DN + k];
      begin_session(KEY_KEY, 3, 4);
      repeat (2000) tick();
      chk("drop busy", 32'(busy), 32'd1);
      chk("drop silent", 32'(ks_valid), 32'd0);
      collect("drop", 4, 1'b0, 1'b1);
      chk_done("drop");
`else
      // illegal key lengths: err pulse, session never starts
      begin_session(KEY_KEY, 0, 10);
      chk("len0 err", 32'(err), 32'd1);
      chk("len0 busy", 32'(busy), 32'd0);
      tick();
      chk("len0 err pulse", 32'(err), 32'd0);
      chk("len0 busy idle", 32'(busy), 32'd0);
      begin_session(KEY_KEY, KB + 1, 10);
      chk("len17 err", 32'(err), 32'd1);
      chk("len17 busy", 32'(busy), 32'd0);
      tick();
      chk("len17 err pulse", 32'(err), 32'd0);

      // "Key", inputs changed after accept and a second start while busy
      begin_session(KEY_KEY, 3, 10);
      key      = '1;
      key_len  = KLW'(1);
      ks_count = CW'(2);
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("key busy", 32'(busy), 32'd1);
      chk("key no err", 32'(err), 32'd0);
      load_exp(256'hEB9F7781B734CA72A719, 10);
      collect("key", 10, 1'b0, 1'b1);
      chk_done("key");

      // "Wiki" with random consumer stalls
      begin_session(KEY_WIKI, 4, 6);
      load_exp(256'h6044DB6D41B7, 6);
      collect("wiki", 6, 1'b1, 1'b1);
      chk_done("wiki");

      // "Secret", unbounded, latency and throughput
      begin_session(KEY_SECRET, 6, 0);
      load_exp(256'h04D46B053CA87B59, 8);
      collect("secret", 8, 1'b0, 1'b0);
      chk("secret first valid cycle", 32'(vt[0]), 32'd1286);
      for (int k = 1; k < 8; k++)
         chk($sformatf("secret spacing %0d", k), 32'(vt[k] - vt[k-1]), 32'd6);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("secret abort valid", 32'(ks_valid), 32'd0);
      chk("secret abort busy", 32'(busy), 32'd0);
      chk("secret abort done", 32'(done), 32'd0);

      // 16-byte key against the software model
      rc4_model(KEY_16, 16, 5);
      for (int k = 0; k < 5; k++) exp_b[k] = mdl[k];
      begin_session(KEY_16, 16, 5);
      collect("key16", 5, 1'b0, 1'b1);
      chk_done("key16");

      // abort mid-KSA, then restart
      begin_session(KEY_KEY, 3, 10);
      repeat (600) tick();
      chk("ksa busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ksa abort busy", 32'(busy), 32'd0);
      chk("ksa abort valid", 32'(ks_valid), 32'd0);
      tick();
      chk("ksa abort no done", 32'(done), 32'd0);
      begin_session(KEY_KEY, 3, 10);
      load_exp(256'hEB9F7781B734CA72A719, 10);
      collect("key after abort", 10, 1'b0, 1'b1);
      chk_done("key after abort");

      // async reset mid-PRGA, then restart
      begin_session(KEY_WIKI, 4, 0);
      load_exp(256'h6044DB6D41B7, 6);
      collect("wiki pre-reset", 3, 1'b0, 1'b0);
      ks_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("mid reset valid", 32'(ks_valid), 32'd0);
      chk("mid reset busy", 32'(busy), 32'd0);
      chk("mid reset data", 32'(ks_data), 32'd0);
      chk("mid reset last", 32'(ks_last), 32'd0);
      chk("mid reset done", 32'(done), 32'd0);
      chk("mid reset err", 32'(err), 32'd0);
      ks_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      begin_session(KEY_KEY, 3, 10);
      load_exp(256'hEB9F7781B734CA72A719, 10);
      collect("key after reset", 10, 1'b0, 1'b1);
      chk_done("key after reset");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
